// File: rtl/spi_cmd_sequencer.sv
// Sequences queued SPI commands into an external SPI controller, one at a
// time, and returns each received word (or a timeout abort) through a
// response FIFO in the order the commands were accepted.
module spi_cmd_sequencer #(
  parameter int LENGTH_SEND_C     = 8,
  parameter int LENGTH_RECIEVED_C = 16,
  parameter int PERIPHERY_SELECT  = 2,
  parameter int DEPTH             = 4,
  parameter int TIMEOUT           = 40
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [LENGTH_SEND_C-1:0]     cmd_data,
  input  logic [PERIPHERY_SELECT-1:0]  cmd_cs,
  output logic                         spi_start,
  output logic [LENGTH_SEND_C-1:0]     spi_data_c,
  output logic [PERIPHERY_SELECT-1:0]  spi_cs,
  input  logic                         spi_done,
  input  logic [LENGTH_RECIEVED_C-1:0] spi_rx_data,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [LENGTH_RECIEVED_C-1:0] rsp_data,
  output logic [PERIPHERY_SELECT-1:0]  rsp_cs,
  output logic                         rsp_err,
  output logic                         busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CMD_W = LENGTH_SEND_C + PERIPHERY_SELECT;
  localparam int RSP_W = LENGTH_RECIEVED_C + PERIPHERY_SELECT + 1;
  localparam logic [7:0]       TMO_LAST = 8'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, STORE} state_t;

  // Command FIFO storage: {cs, data}
  logic [CMD_W-1:0] cmd_mem_q [DEPTH];
  logic [PTR_W-1:0] cmd_wr_ptr_q, cmd_rd_ptr_q;
  logic [CNT_W-1:0] cmd_count_q;
  logic             cmd_push, cmd_pop;
  logic [CMD_W-1:0] cmd_head;

  // Response FIFO storage: {data, cs, err}
  logic [RSP_W-1:0] rsp_mem_q [DEPTH];
  logic [PTR_W-1:0] rsp_wr_ptr_q, rsp_rd_ptr_q;
  logic [CNT_W-1:0] rsp_count_q;
  logic             rsp_push, rsp_pop;
  logic [RSP_W-1:0] rsp_head;

  // Sequencer state
  state_t                       state_q, state_d;
  logic [7:0]                   tmo_q, tmo_d;
  logic [LENGTH_RECIEVED_C-1:0] rx_q, rx_d;
  logic                         err_q, err_d;
  logic [LENGTH_SEND_C-1:0]     spi_data_q, spi_data_d;
  logic [PERIPHERY_SELECT-1:0]  spi_cs_q, spi_cs_d;

  assign cmd_ready = (cmd_count_q != FULL_CNT);
  assign cmd_push  = cmd_valid && cmd_ready;
  assign cmd_head  = cmd_mem_q[cmd_rd_ptr_q];

  assign rsp_valid = (rsp_count_q != '0);
  assign rsp_pop   = rsp_valid && rsp_ready;
  assign rsp_head  = rsp_mem_q[rsp_rd_ptr_q];

  // Gate the head fields so stale storage never shows while the FIFO is empty
  assign rsp_data  = rsp_valid ? rsp_head[RSP_W-1 -: LENGTH_RECIEVED_C] : '0;
  assign rsp_cs    = rsp_valid ? rsp_head[PERIPHERY_SELECT:1] : '0;
  assign rsp_err   = rsp_valid & rsp_head[0];

  assign spi_start  = (state_q == ISSUE);
  assign busy       = (state_q != IDLE);
  assign spi_data_c = spi_data_q;
  assign spi_cs     = spi_cs_q;

  // Command FIFO storage write (no reset needed, validity tracked by count)
  always_ff @(posedge clk) begin
    if (cmd_push) cmd_mem_q[cmd_wr_ptr_q] <= {cmd_cs, cmd_data};
  end

  // Command FIFO pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_wr_ptr_q <= '0;
      cmd_rd_ptr_q <= '0;
      cmd_count_q  <= '0;
    end else begin
      if (cmd_push) cmd_wr_ptr_q <= cmd_wr_ptr_q + PTR_W'(1);
      if (cmd_pop)  cmd_rd_ptr_q <= cmd_rd_ptr_q + PTR_W'(1);
      case ({cmd_push, cmd_pop})
        2'b10:   cmd_count_q <= cmd_count_q + CNT_W'(1);
        2'b01:   cmd_count_q <= cmd_count_q - CNT_W'(1);
        default: cmd_count_q <= cmd_count_q;
      endcase
    end
  end

  // Response FIFO storage write
  always_ff @(posedge clk) begin
    if (rsp_push) rsp_mem_q[rsp_wr_ptr_q] <= {rx_q, spi_cs_q, err_q};
  end

  // Response FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_wr_ptr_q <= '0;
      rsp_rd_ptr_q <= '0;
      rsp_count_q  <= '0;
    end else begin
      if (rsp_push) rsp_wr_ptr_q <= rsp_wr_ptr_q + PTR_W'(1);
      if (rsp_pop)  rsp_rd_ptr_q <= rsp_rd_ptr_q + PTR_W'(1);
      case ({rsp_push, rsp_pop})
        2'b10:   rsp_count_q <= rsp_count_q + CNT_W'(1);
        2'b01:   rsp_count_q <= rsp_count_q - CNT_W'(1);
        default: rsp_count_q <= rsp_count_q;
      endcase
    end
  end

  // Sequencer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tmo_q      <= '0;
      rx_q       <= '0;
      err_q      <= 1'b0;
      spi_data_q <= '0;
      spi_cs_q   <= '0;
    end else begin
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      rx_q       <= rx_d;
      err_q      <= err_d;
      spi_data_q <= spi_data_d;
      spi_cs_q   <= spi_cs_d;
    end
  end

  // Next-state logic; a command is only issued when a response slot is free,
  // so STORE can always push without checking for room
  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    rx_d       = rx_q;
    err_d      = err_q;
    spi_data_d = spi_data_q;
    spi_cs_d   = spi_cs_q;
    cmd_pop    = 1'b0;
    rsp_push   = 1'b0;
    case (state_q)
      IDLE: begin
        if ((cmd_count_q != '0) && (rsp_count_q != FULL_CNT)) begin
          cmd_pop    = 1'b1;
          spi_data_d = cmd_head[LENGTH_SEND_C-1:0];
          spi_cs_d   = cmd_head[CMD_W-1 -: PERIPHERY_SELECT];
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        tmo_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (spi_done) begin
          rx_d    = spi_rx_data;
          err_d   = 1'b0;
          state_d = STORE;
        end else if (tmo_q == TMO_LAST) begin
          rx_d    = '0;
          err_d   = 1'b1;
          state_d = STORE;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      STORE: begin
        rsp_push = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/spi_cmd_sequencer.md
SPI_CMD_SEQUENCER -- requirements
Module: spi_cmd_sequencer

Interface
REQ-001 SHALL have parameter LENGTH_SEND_C, default 8, width of the command data word sent controller->peripheral.
REQ-002 SHALL have parameter LENGTH_RECIEVED_C, default 16, width of the response word received peripheral->controller.
REQ-003 SHALL have parameter PERIPHERY_SELECT, default 2, width of the peripheral select field.
REQ-004 SHALL have parameter DEPTH, default 4, number of entries in each of the command FIFO and response FIFO; power of two, at least 2.
REQ-005 SHALL have parameter TIMEOUT, default 40, maximum cycles spent in WAIT before abort; 8-bit counter.
REQ-006 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port cmd_valid, input, 1, command offered.
REQ-009 SHALL have port cmd_ready, output, 1, command FIFO not full.
REQ-010 SHALL have port cmd_data, input, LENGTH_SEND_C, word to transmit.
REQ-011 SHALL have port cmd_cs, input, PERIPHERY_SELECT, target peripheral.
REQ-012 SHALL have port spi_start, output, 1, one-cycle pulse that starts the SPI controller (drives start_comm).
REQ-013 SHALL have port spi_data_c, output, LENGTH_SEND_C, word to the SPI controller (drives data_send_c).
REQ-014 SHALL have port spi_cs, output, PERIPHERY_SELECT, peripheral select (drives CS_in).
REQ-015 SHALL have port spi_done, input, 1, one-cycle pulse from the SPI controller when the receive word is complete.
REQ-016 SHALL have port spi_rx_data, input, LENGTH_RECIEVED_C, received word; valid in the spi_done cycle.
REQ-017 SHALL have port rsp_valid, output, 1, response FIFO not empty.
REQ-018 SHALL have port rsp_ready, input, 1, consumer accepts the response.
REQ-019 SHALL have port rsp_data, output, LENGTH_RECIEVED_C, response word.
REQ-020 SHALL have port rsp_cs, output, PERIPHERY_SELECT, peripheral the response came from.
REQ-021 SHALL have port rsp_err, output, 1, 1 = timeout abort; rsp_data is then 0.
REQ-022 SHALL have port busy, output, 1, state is not IDLE.

Function
REQ-023 A command SHALL be written to the command FIFO in every cycle with cmd_valid=1 and cmd_ready=1; cmd_ready SHALL be 0 exactly when the command FIFO holds DEPTH entries.
REQ-024 A response SHALL be popped in every cycle with rsp_valid=1 and rsp_ready=1; rsp_data, rsp_cs and rsp_err SHALL show the head entry and SHALL hold while rsp_ready=0.
REQ-025 FSM states SHALL be IDLE, ISSUE, WAIT and STORE.
REQ-026 IDLE->ISSUE SHALL occur when the command FIFO is non-empty and the response FIFO has at least one free entry; the command is popped and latched into spi_data_c and spi_cs.
REQ-027 In ISSUE, spi_start SHALL be 1 for exactly one cycle, then the FSM SHALL go to WAIT with the timeout counter cleared.
REQ-028 spi_data_c and spi_cs SHALL stay stable from ISSUE until the FSM returns to IDLE.
REQ-029 In WAIT, spi_done=1 SHALL capture spi_rx_data and go to STORE; otherwise the counter SHALL increment, and on reaching TIMEOUT-1 the FSM SHALL go to STORE with err=1 and data=0.
REQ-030 In STORE, the FSM SHALL push {data, cs, err} into the response FIFO and go to IDLE; total latency from spi_done to rsp_valid SHALL be 2 cycles when the response FIFO was empty.
REQ-031 spi_done outside WAIT SHALL be ignored.
REQ-032 A simultaneous command push and command pop SHALL leave the count unchanged; the same SHALL hold for the response FIFO.
REQ-033 FIFO pointers SHALL wrap modulo DEPTH with no lost or duplicated entries.
REQ-034 Commands SHALL be issued strictly in order, with at most one SPI transaction outstanding.

Reset
REQ-035 While rst=1 at a clock edge, both FIFOs SHALL empty, the FSM SHALL go to IDLE and the counter SHALL clear; spi_start, rsp_valid, busy, rsp_err, spi_data_c and spi_cs SHALL be 0, and cmd_ready SHALL be 1 from the following cycle.
REQ-036 Reset mid-WAIT SHALL drop the outstanding transaction with no response pushed; a later spi_done SHALL be ignored.

Verification
REQ-037 Single command: push cmd_data=0xA5, cmd_cs=2 -> one spi_start pulse, spi_data_c=0xA5, spi_cs=2; spi_done with spi_rx_data=0xBEEF -> rsp_data=0xBEEF, rsp_cs=2, rsp_err=0 two cycles later.
REQ-038 Fill: push 5 commands with rsp_ready=0 and no spi_done -> cmd_ready=0 after 4 buffered commands, beyond the one in flight; no push lost.
REQ-039 Backpressure: rsp_ready=0 through 4 completed transactions -> response FIFO full, FSM holds in IDLE with no spi_start; rsp_ready=1 -> 4 responses drain in order, then the 5th issues.
REQ-040 Timeout: push a command and never assert spi_done -> after TIMEOUT=40 WAIT cycles, rsp_err=1, rsp_data=0x0000 is pushed and the next command issues.
REQ-041 Reset during WAIT, then an spi_done pulse -> rsp_valid stays 0, busy=0, cmd_ready=1.
REQ-042 Random stream of 100 commands with random cs (0..3) against the SPI controller model -> responses in order, each matching its cs, no spurious spi_start.
